// File: rtl/tcm_mem_lat_if.sv
// Core-side bus of the TCM model: 64-bit fetch port, tagged 32-bit data port, tohost exit.
// master = core / testbench side, slave = memory side.
interface tcm_mem_lat_if;
    logic        mem_i_rd_i;
    logic        mem_i_flush_i;
    logic        mem_i_invalidate_i;
    logic [31:0] mem_i_pc_i;
    logic        mem_i_accept_o;
    logic        mem_i_valid_o;
    logic        mem_i_error_o;
    logic [63:0] mem_i_inst_o;

    logic [31:0] mem_d_addr_i;
    logic [31:0] mem_d_data_wr_i;
    logic        mem_d_rd_i;
    logic [3:0]  mem_d_wr_i;
    logic        mem_d_cacheable_i;
    logic [10:0] mem_d_req_tag_i;
    logic        mem_d_invalidate_i;
    logic        mem_d_writeback_i;
    logic        mem_d_flush_i;
    logic [31:0] mem_d_data_rd_o;
    logic        mem_d_accept_o;
    logic        mem_d_ack_o;
    logic        mem_d_error_o;
    logic [10:0] mem_d_resp_tag_o;

    logic        exit_o;
    logic [30:0] exit_code_o;

    modport master (
        output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
        output mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
        input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o,
        input  exit_o, exit_code_o
    );

    modport slave (
        input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
        output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
        input  mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
        output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o,
        output exit_o, exit_code_o
    );
endinterface

// File: rtl/tcm_mem_lat.sv
// Simulation TCM model: byte-array memory behind a fetch port and a tagged data port,
// with fixed per-port response latency, LFSR accept back-pressure and a tohost exit detector.
module tcm_mem_lat #(
    parameter int unsigned MEM_BYTES   = 131072,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned I_LATENCY   = 1,
    parameter int unsigned D_LATENCY   = 1,
    parameter bit          STALL_EN    = 1'b0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000
) (
    input logic           clk_i,
    input logic           rst_i,
    tcm_mem_lat_if.slave  bus
);
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int I_STG = I_LATENCY - 1;
    localparam int D_STG = D_LATENCY - 1;

    typedef struct packed {
        logic        err;
        logic [63:0] inst;
    } i_rsp_t;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [10:0] tag;
    } d_rsp_t;

    logic [7:0] mem [MEM_BYTES];

    // Accept is a pure function of registered state so it never loops back through the core.
    logic [15:0] lfsr;
    logic        accept;

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign accept             = STALL_EN ? (lfsr[0] | lfsr[5]) : 1'b1;
    assign bus.mem_i_accept_o = accept;
    assign bus.mem_d_accept_o = accept;

    // Fetch side
    logic        i_req, i_take, i_rd_take, i_ok;
    logic [31:0] i_off;
    logic [63:0] i_rdata;
    i_rsp_t      i_in;

    assign i_req     = bus.mem_i_rd_i | bus.mem_i_flush_i | bus.mem_i_invalidate_i;
    assign i_take    = i_req & accept;
    assign i_rd_take = i_take & bus.mem_i_rd_i;
    // An address below BASE_ADDR wraps to a huge offset, so one compare covers both bounds.
    assign i_off     = {bus.mem_i_pc_i[31:3], 3'b000} - BASE_ADDR;
    assign i_ok      = i_off < MEM_BYTES;

    always_comb begin
        i_rdata = '0;
        for (int k = 0; k < 8; k++)
            i_rdata[8*k +: 8] = mem[{i_off[AW-1:3], 3'(k)}];
    end

    always_comb begin
        i_in = '0;
        if (i_rd_take) begin
            i_in.err  = ~i_ok;
            i_in.inst = i_ok ? i_rdata : '0;
        end
    end

    // Data side
    logic        d_req, d_take, d_rw, d_ok;
    logic [31:0] d_wd, d_off, d_rdata;
    d_rsp_t      d_in;

    assign d_req  = bus.mem_d_rd_i | (|bus.mem_d_wr_i) | bus.mem_d_invalidate_i
                  | bus.mem_d_writeback_i | bus.mem_d_flush_i;
    assign d_take = d_req & accept;
    assign d_rw   = bus.mem_d_rd_i | (|bus.mem_d_wr_i);
    assign d_wd   = {bus.mem_d_addr_i[31:2], 2'b00};
    assign d_off  = d_wd - BASE_ADDR;
    assign d_ok   = d_off < MEM_BYTES;

    always_comb begin
        d_rdata = '0;
        for (int k = 0; k < 4; k++)
            d_rdata[8*k +: 8] = mem[{d_off[AW-1:2], 2'(k)}];
    end

    always_comb begin
        d_in = '0;
        if (d_take) begin
            d_in.err  = d_rw & ~d_ok;
            d_in.data = (bus.mem_d_rd_i & d_ok) ? d_rdata : '0;
            d_in.tag  = bus.mem_d_req_tag_i;
        end
    end

    // Plain always: the backdoor task below also writes the array.
    always @(posedge clk_i) begin
        if (!rst_i && d_take && d_ok) begin
            for (int k = 0; k < 4; k++)
                if (bus.mem_d_wr_i[k])
                    mem[{d_off[AW-1:2], 2'(k)}] <= bus.mem_d_data_wr_i[8*k +: 8];
        end
    end

    // Response pipelines; payload is zero when no request was taken, so idle outputs read 0.
    logic [I_STG:0] i_vld_pipe;
    i_rsp_t         i_pipe [I_STG:0];
    logic [D_STG:0] d_vld_pipe;
    d_rsp_t         d_pipe [D_STG:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_vld_pipe <= '0;
            for (int s = 0; s <= I_STG; s++) i_pipe[s] <= '0;
        end else begin
            i_vld_pipe[0] <= i_rd_take;
            i_pipe[0]     <= i_in;
            for (int s = 1; s <= I_STG; s++) begin
                i_vld_pipe[s] <= i_vld_pipe[s-1];
                i_pipe[s]     <= i_pipe[s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_vld_pipe <= '0;
            for (int s = 0; s <= D_STG; s++) d_pipe[s] <= '0;
        end else begin
            d_vld_pipe[0] <= d_take;
            d_pipe[0]     <= d_in;
            for (int s = 1; s <= D_STG; s++) begin
                d_vld_pipe[s] <= d_vld_pipe[s-1];
                d_pipe[s]     <= d_pipe[s-1];
            end
        end
    end

    assign bus.mem_i_valid_o    = i_vld_pipe[I_STG];
    assign bus.mem_i_error_o    = i_pipe[I_STG].err;
    assign bus.mem_i_inst_o     = i_pipe[I_STG].inst;
    assign bus.mem_d_ack_o      = d_vld_pipe[D_STG];
    assign bus.mem_d_error_o    = d_pipe[D_STG].err;
    assign bus.mem_d_data_rd_o  = d_pipe[D_STG].data;
    assign bus.mem_d_resp_tag_o = d_pipe[D_STG].tag;

    // First qualifying tohost write wins; later ones only update the array.
    logic        exit_q;
    logic [30:0] exit_code_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exit_q      <= 1'b0;
            exit_code_q <= '0;
        end else if (d_take && bus.mem_d_wr_i == 4'hF && d_wd == TOHOST_ADDR
                     && bus.mem_d_data_wr_i[0] && !exit_q) begin
            exit_q      <= 1'b1;
            exit_code_q <= bus.mem_d_data_wr_i[31:1];
        end
    end

    assign bus.exit_o      = exit_q;
    assign bus.exit_code_o = exit_code_q;

    logic unused_cacheable;
    assign unused_cacheable = bus.mem_d_cacheable_i;

    // Backdoor preload at an array offset; bypasses range checking.
    task automatic write(input logic [AW-1:0] addr, input logic [7:0] data);
        mem[addr] <= data;
    endtask
endmodule
